regfile_wb_arbiter: RTL and testbench

- Write-back arbiter for the 4 x 24-bit register file.
- Shares its single write port (write_reg / reg_write / write_data) between NUM_REQ producers, e.g. ALU write-back and load unit, using valid/ready handshakes.
- Registers the winning request into an output stage that drives the register file directly.
- Reports which registers have a write in flight, and counts arbitration stalls.

---
 rtl/regfile_wb_arbiter_if.sv | 22 ++
 rtl/regfile_wb_arbiter.sv | 57 +++++
 tb/tb_regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester valid/ready bundle plus the register-file write port
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]         write_reg;
  logic                      reg_write;
  logic [DATA_W-1:0]         write_data;
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, write_reg, reg_write, write_data
  );
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, write_reg, reg_write, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port among NUM_REQ requesters.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 2,
  parameter int NUM_REGS = 4,
  parameter int STALL_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wb_enable,
  regfile_wb_arbiter_if.slave  bus,
  output logic [1:0]           grant_id,
  output logic [NUM_REGS-1:0]  busy_mask,
  output logic [STALL_W-1:0]   stall_count
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nx;
  logic [1:0] win;
  logic hs;
`ifdef WB_ARB_RR_EN
  logic [1:0] ptr;
  always_ff @(posedge clock)
    if (reset) ptr <= '0;
    else if (hs) ptr <= (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
`endif
  // lowest valid index overall; round-robin then prefers the lowest at or above ptr
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (bus.req_valid[k]) win = 2'(k);
`ifdef WB_ARB_RR_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) if (bus.req_valid[k] && 2'(k) >= ptr) win = 2'(k);
`endif
  end
  assign hs = wb_enable && !reset && |bus.req_valid;
  assign bus.req_ready = hs ? (NUM_REQ'(1) << win) : '0;
  always_ff @(posedge clock) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = hs ? WRITE : IDLE;
    bus.reg_write = state == WRITE;
    busy_mask = (state == WRITE) ? (NUM_REGS'(1) << bus.write_reg) : '0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      bus.write_reg  <= '0;
      bus.write_data <= '0;
      grant_id       <= '0;
    end else if (hs) begin
      bus.write_reg  <= bus.req_addr[win*ADDR_W +: ADDR_W];
      bus.write_data <= bus.req_data[win*DATA_W +: DATA_W];
      grant_id       <= win;
    end
  always_ff @(posedge clock)
    if (reset) stall_count <= '0;
    else if (|(bus.req_valid & ~bus.req_ready) && stall_count != '1) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random stimulus against a behavioural arbiter/regfile model
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int N = 2, DW = 24, AW = 2, NR = 4;
  logic clock = 0, reset = 1, wb_enable = 1;
  logic [1:0] grant_id, grant_id_s;
  logic [NR-1:0] busy_mask, busy_mask_s;
  logic [7:0] stall_count;
  logic [1:0] stall_count_s;
  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus_s ();
  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .STALL_W(8)) dut (
    .clock(clock), .reset(reset), .wb_enable(wb_enable), .bus(bus),
    .grant_id(grant_id), .busy_mask(busy_mask), .stall_count(stall_count));
  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .STALL_W(2)) dut_s (
    .clock(clock), .reset(reset), .wb_enable(wb_enable), .bus(bus_s),
    .grant_id(grant_id_s), .busy_mask(busy_mask_s), .stall_count(stall_count_s));
  assign bus_s.req_valid = bus.req_valid;
  assign bus_s.req_addr  = bus.req_addr;
  assign bus_s.req_data  = bus.req_data;
  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  logic m_rw = 0;
  logic [AW-1:0] m_reg = 0;
  logic [DW-1:0] m_data = 0;
  logic [1:0] m_gid = 0;
  int m_stall = 0, m_stall_s = 0, m_ptr = 0;
  logic [DW-1:0] m_rf[NR] = '{default: 0};
  logic [DW-1:0] tb_rf[NR] = '{default: 0};
  logic pv[N] = '{default: 0};
  logic [AW-1:0] pa[N] = '{default: 0};
  logic [DW-1:0] pd[N] = '{default: 0};
  logic [N-1:0] last_g = 0;

  always @(posedge clock) if (bus.reg_write) tb_rf[bus.write_reg] <= bus.write_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pv[i];
      bus.req_addr[i*AW +: AW] = pa[i];
      bus.req_data[i*DW +: DW] = pd[i];
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    int idx;
    if (reset || !wb_enable) return '0;
    for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_RR_EN
      idx = (m_ptr + k) % N;
`else
      idx = k;
`endif
      if (pv[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic tick();
    logic [N-1:0] g;
    logic stalled;
    int gi;
    drive();
    #1;
    g = exp_grant();
    check("req_ready", 32'(bus.req_ready), 32'(g));
    @(posedge clock);
    if (m_rw) m_rf[m_reg] = m_data;
    if (reset) begin
      m_rw = 0; m_reg = 0; m_data = 0; m_gid = 0; m_stall = 0; m_stall_s = 0; m_ptr = 0;
    end else begin
      stalled = 0;
      gi = 0;
      for (int i = 0; i < N; i++) begin
        if (pv[i] && !g[i]) stalled = 1;
        if (g[i]) gi = i;
      end
      if (stalled) begin
        if (m_stall < 255) m_stall++;
        if (m_stall_s < 3) m_stall_s++;
      end
      m_rw = |g;
      if (|g) begin
        m_reg = pa[gi]; m_data = pd[gi]; m_gid = 2'(gi); m_ptr = (gi + 1) % N;
      end
    end
    last_g = g;
    for (int i = 0; i < N; i++) if (g[i]) pv[i] = 0;
    #1;
    check("reg_write", 32'(bus.reg_write), 32'(m_rw));
    check("write_reg", 32'(bus.write_reg), 32'(m_reg));
    check("write_data", 32'(bus.write_data), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("busy_mask", 32'(busy_mask), m_rw ? (32'd1 << m_reg) : 32'd0);
    check("stall_count", 32'(stall_count), 32'(m_stall));
    check("stall_count_sat", 32'(stall_count_s), 32'(m_stall_s));
    @(negedge clock);
  endtask

  initial begin
    reset = 1;
    tick(); tick();
    reset = 0;
    tick(); tick();
    check("idle_reg_write", 32'(bus.reg_write), 0);
    check("idle_stall", 32'(stall_count), 0);
    // single write from requester 1
    pv[1] = 1; pa[1] = 2; pd[1] = 24'hABCDEF;
    tick();
    check("single_ready", 32'(last_g), 32'b10);
    check("single_data", 32'(bus.write_data), 32'hABCDEF);
    check("single_busy", 32'(busy_mask), 32'b0100);
    check("single_gid", 32'(grant_id), 1);
    tick();
    check("single_done", 32'(bus.reg_write), 0);
    // collision on register 3
    pv[0] = 1; pa[0] = 3; pd[0] = 24'h000011;
    pv[1] = 1; pa[1] = 3; pd[1] = 24'h000022;
    tick();
    check("coll_first", 32'(bus.write_data), 32'h11);
    tick();
    check("coll_second", 32'(bus.write_data), 32'h22);
    check("coll_stall", 32'(stall_count), 1);
    tick();
    check("coll_rf", 32'(tb_rf[3]), 32'h22);
    // wb_enable held low
    reset = 1; tick(); reset = 0;
    wb_enable = 0; pv[0] = 1; pa[0] = 1; pd[0] = 24'h000005;
    tick(); tick(); tick();
    check("en_stall", 32'(stall_count), 3);
    wb_enable = 1;
    tick();
    check("en_grant", 32'(last_g), 1);
    check("en_write", 32'(bus.reg_write), 1);
    // reset the cycle after a handshake
    pv[0] = 1; pa[0] = 2; pd[0] = 24'h123456;
    tick();
    check("mid_write", 32'(bus.reg_write), 1);
    reset = 1; tick(); reset = 0;
    check("mid_drop", 32'(bus.reg_write), 0);
    // saturation of the narrow counter
    wb_enable = 0; pv[0] = 1; pa[0] = 0; pd[0] = 24'h000077;
    for (int k = 0; k < 5; k++) tick();
    check("sat_narrow", 32'(stall_count_s), 3);
    check("sat_wide", 32'(stall_count), 5);
    wb_enable = 1;
`ifdef WB_ARB_RR_EN
    reset = 1; tick(); reset = 0;
    for (int k = 0; k < 6; k++) begin
      pv[0] = 1; pa[0] = 0; pd[0] = 24'(k);
      pv[1] = 1; pa[1] = 1; pd[1] = 24'(k + 100);
      tick();
      check("rr_gid", 32'(grant_id), 32'(k % 2));
      check("rr_write", 32'(bus.reg_write), 1);
    end
`endif
    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; pa[i] = AW'($urandom); pd[i] = DW'($urandom);
        end
      wb_enable = $urandom_range(0, 9) != 0;
      reset = $urandom_range(0, 49) == 0;
      tick();
    end
    reset = 0; wb_enable = 1;
    for (int i = 0; i < N; i++) pv[i] = 0;
    tick(); tick();
    for (int r = 0; r < NR; r++) check("rf_contents", 32'(tb_rf[r]), 32'(m_rf[r]));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
